// File: rtl/seq_tx.sv
`default_nettype none
// ============================================================================
//  Module   : seq_tx
//  Purpose  : Serial pattern transmitter. Shifts a programmable bit pattern
//             out MSB-first, one bit per clock, repeating it a programmable
//             number of times with a programmable idle gap between frames.
//             out_bit is meant to drive a sequence detector's serial input.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   system clock, rising edge
//    reset      in   synchronous, active-high reset
//    start      in   request to send; sampled only while idle
//    pattern    in   WIDTH   pattern bits, LSB-aligned, sent bit len-1 .. 0
//    len        in   $clog2(WIDTH)+1  pattern length; 0 or >WIDTH -> WIDTH
//    repeat_n   in   CNT_W   number of frames; 0 -> 1
//    gap        in   GAP_W   idle cycles between frames; 0 -> back-to-back
//    out_bit    out  serial data (registered)
//    valid      out  high while out_bit carries a pattern bit
//    busy       out  high while shifting or in an inter-frame gap
//    done       out  one-cycle pulse after the last bit of the last frame
//    frame_cnt  out  CNT_W   frames completed since the last accepted start
//    led        out  3       state display: IDLE 001 SHIFT 010 GAP 100 DONE 111
// ============================================================================
module seq_tx #(
  parameter int WIDTH = 8,   // maximum pattern length, must be >= 2
  parameter int CNT_W = 4,
  parameter int GAP_W = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WIDTH-1:0]       pattern,
  input  logic [$clog2(WIDTH):0] len,
  input  logic [CNT_W-1:0]       repeat_n,
  input  logic [GAP_W-1:0]       gap,
  output logic                   out_bit,
  output logic                   valid,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       frame_cnt,
  output logic [2:0]             led
);

  localparam int LEN_W = $clog2(WIDTH) + 1;
  localparam int IDX_W = $clog2(WIDTH);

  localparam logic [LEN_W-1:0] LEN_ZERO  = '0;
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(WIDTH);
  localparam logic [IDX_W-1:0] IDX_ZERO  = '0;
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [GAP_W-1:0] GAP_ZERO  = '0;
  localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);

  localparam logic [2:0] LED_IDLE  = 3'b001;
  localparam logic [2:0] LED_SHIFT = 3'b010;
  localparam logic [2:0] LED_GAP   = 3'b100;
  localparam logic [2:0] LED_DONE  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] pat_q,       pat_d;
  logic [IDX_W-1:0] last_idx_q,  last_idx_d;   // effective length minus one
  logic [CNT_W-1:0] rep_q,       rep_d;        // effective frame count (>=1)
  logic [GAP_W-1:0] gap_q,       gap_d;
  logic [IDX_W-1:0] bit_idx_q,   bit_idx_d;    // index of bit on out_bit now
  logic [GAP_W-1:0] gap_cnt_q,   gap_cnt_d;    // gap cycles left after this one
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             out_bit_q,   out_bit_d;
  logic             valid_q,     valid_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic [2:0]       led_q,       led_d;

  // Effective parameters derived from the raw inputs at start time
  logic [LEN_W-1:0] len_dec;
  logic [IDX_W-1:0] len_eff_m1;
  logic [CNT_W-1:0] rep_eff;
  logic [IDX_W-1:0] bit_idx_dec;
  logic [CNT_W-1:0] frame_inc;
  logic             last_frame;

  always_comb begin
    len_dec     = len - LEN_ONE;
    len_eff_m1  = ((len == LEN_ZERO) || (len > LEN_MAX)) ? IDX_TOP
                                                         : len_dec[IDX_W-1:0];
    rep_eff     = (repeat_n == CNT_ZERO) ? CNT_ONE : repeat_n;
    bit_idx_dec = bit_idx_q - IDX_ONE;
    // Saturating increment; with rep_q <= CNT_MAX it never actually clips.
    frame_inc   = (frame_cnt_q == CNT_MAX) ? frame_cnt_q : frame_cnt_q + CNT_ONE;
    last_frame  = (frame_inc == rep_q);
  end

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    last_idx_d  = last_idx_q;
    rep_d       = rep_q;
    gap_d       = gap_q;
    bit_idx_d   = bit_idx_q;
    gap_cnt_d   = gap_cnt_q;
    frame_cnt_d = frame_cnt_q;
    out_bit_d   = out_bit_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    led_d       = led_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_d       = pattern;
          last_idx_d  = len_eff_m1;
          rep_d       = rep_eff;
          gap_d       = gap;
          bit_idx_d   = len_eff_m1;
          frame_cnt_d = CNT_ZERO;
          out_bit_d   = pattern[len_eff_m1];
          valid_d     = 1'b1;
          busy_d      = 1'b1;
          led_d       = LED_SHIFT;
          state_d     = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (bit_idx_q != IDX_ZERO) begin
          bit_idx_d = bit_idx_dec;
          out_bit_d = pat_q[bit_idx_dec];
        end else begin
          // Bit 0 has been on the line for a cycle: the frame is complete.
          frame_cnt_d = frame_inc;
          if (last_frame) begin
            out_bit_d = 1'b0;
            valid_d   = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            led_d     = LED_DONE;
            state_d   = S_DONE;
          end else if (gap_q != GAP_ZERO) begin
            gap_cnt_d = gap_q - GAP_ONE;
            out_bit_d = 1'b0;
            valid_d   = 1'b0;
            led_d     = LED_GAP;
            state_d   = S_GAP;
          end else begin
            // Back-to-back: next frame's MSB follows with no bubble.
            bit_idx_d = last_idx_q;
            out_bit_d = pat_q[last_idx_q];
          end
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_ZERO) begin
          bit_idx_d = last_idx_q;
          out_bit_d = pat_q[last_idx_q];
          valid_d   = 1'b1;
          led_d     = LED_SHIFT;
          state_d   = S_SHIFT;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end
      end

      S_DONE: begin
        led_d   = LED_IDLE;
        state_d = S_IDLE;
      end

      default: begin
        out_bit_d = 1'b0;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        led_d     = LED_IDLE;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pat_q       <= '0;
      last_idx_q  <= '0;
      rep_q       <= CNT_ONE;
      gap_q       <= '0;
      bit_idx_q   <= '0;
      gap_cnt_q   <= '0;
      frame_cnt_q <= '0;
      out_bit_q   <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      led_q       <= LED_IDLE;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      last_idx_q  <= last_idx_d;
      rep_q       <= rep_d;
      gap_q       <= gap_d;
      bit_idx_q   <= bit_idx_d;
      gap_cnt_q   <= gap_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      out_bit_q   <= out_bit_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      led_q       <= led_d;
    end
  end

  assign out_bit   = out_bit_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_cnt = frame_cnt_q;
  assign led       = led_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_tx
//  Purpose  : Self-checking bench for seq_tx. A frame-level model expands each
//             accepted start into the full per-cycle output sequence; a
//             compare process checks every cycle, and directed cases add
//             literal expectations on latency, done timing and frame count.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_tx;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] repeat_n;
  logic [2:0] gap;
  logic       out_bit;
  logic       valid;
  logic       busy;
  logic       done;
  logic [3:0] frame_cnt;
  logic [2:0] led;

  int checks = 0;
  int errors = 0;

  seq_tx #(.WIDTH(8), .CNT_W(4), .GAP_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pattern   (pattern),
    .len       (len),
    .repeat_n  (repeat_n),
    .gap       (gap),
    .out_bit   (out_bit),
    .valid     (valid),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt),
    .led       (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic       ob;
    logic       v;
    logic       b;
    logic       d;
    logic [3:0] fc;
    logic [2:0] led;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_c = '0;
  logic [3:0] hold_fc = '0;
  logic model_ok = 1'b0;

  always @(posedge clk) begin : model
    int   nl, nr, ng;
    exp_t e;
    if (reset) begin
      exp_q.delete();
      hold_fc  = 4'd0;
      exp_c    = '0;
      exp_c.led = 3'b001;
      model_ok = 1'b1;
    end else if (exp_q.size() == 0 && !exp_c.d && start) begin
      nl = (len == 0 || len > 8) ? 8 : int'(len);
      nr = (repeat_n == 0) ? 1 : int'(repeat_n);
      ng = int'(gap);
      for (int f = 0; f < nr; f++) begin
        for (int i = nl - 1; i >= 0; i--) begin
          e = '0; e.ob = pattern[i]; e.v = 1'b1; e.b = 1'b1;
          e.fc = 4'(f); e.led = 3'b010;
          exp_q.push_back(e);
        end
        if (f < nr - 1) begin
          for (int g = 0; g < ng; g++) begin
            e = '0; e.b = 1'b1; e.fc = 4'(f + 1); e.led = 3'b100;
            exp_q.push_back(e);
          end
        end
      end
      e = '0; e.d = 1'b1; e.fc = 4'(nr); e.led = 3'b111;
      exp_q.push_back(e);
      hold_fc = 4'(nr);
      exp_c = exp_q.pop_front();
    end else if (exp_q.size() > 0) begin
      exp_c = exp_q.pop_front();
    end else begin
      exp_c = '0; exp_c.fc = hold_fc; exp_c.led = 3'b001;
    end
  end

  // ---------------------------------------------------------- compare
  always @(negedge clk) begin
    exp_t act;
    if (model_ok) begin
      act = {out_bit, valid, busy, done, frame_cnt, led};
      checks++;
      if (act !== exp_c) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t: got ob=%b v=%b b=%b d=%b fc=%0d led=%b, expected ob=%b v=%b b=%b d=%b fc=%0d led=%b",
                 $time, act.ob, act.v, act.b, act.d, act.fc, act.led,
                 exp_c.ob, exp_c.v, exp_c.b, exp_c.d, exp_c.fc, exp_c.led);
      end
    end
  end

  // ------------------------------------------------------------ helpers
  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Pulse start for one cycle, scramble the inputs afterwards, then check
  // the first bit, the cycle of the done pulse (first bit = cycle 1), the
  // final frame count and the return to IDLE.
  task automatic send(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                      input logic [2:0] g, input int done_cyc, input logic [3:0] fc_exp,
                      input logic first_bit);
    int n;
    pattern = p; len = l; repeat_n = r; gap = g; start = 1'b1;
    @(negedge clk);
    start = 1'b0; pattern = ~p; len = 4'd2; repeat_n = 4'd9; gap = 3'd1;
    lit("first_bit", 32'(out_bit), 32'(first_bit));
    lit("first_led", 32'(led), 32'h2);
    n = 1;
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    lit("done_cycle", 32'(n), 32'(done_cyc));
    lit("frame_cnt_at_done", 32'(frame_cnt), 32'(fc_exp));
    @(negedge clk);
    lit("led_idle_after", 32'(led), 32'h1);
    lit("frame_cnt_hold", 32'(frame_cnt), 32'(fc_exp));
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    reset = 1'b1; start = 1'b1; pattern = 8'h15; len = 4'd5; repeat_n = 4'd1; gap = 3'd0;
    repeat (2) @(negedge clk);
    lit("rst_led", 32'(led), 32'h1);
    lit("rst_valid_busy_done", 32'({valid, busy, done, out_bit}), 32'h0);
    lit("rst_frame_cnt", 32'(frame_cnt), 32'h0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);

    send(8'h15, 4'd5, 4'd1, 3'd0, 6, 4'd1, 1'b1);    // 10101 single frame
    send(8'h15, 4'd5, 4'd3, 3'd2, 20, 4'd3, 1'b1);   // three frames, gap 2
    send(8'h06, 4'd3, 4'd2, 3'd0, 7, 4'd2, 1'b1);    // 110110 back-to-back
    send(8'hA5, 4'd0, 4'd0, 3'd5, 9, 4'd1, 1'b1);    // len 0 -> 8, repeat 0 -> 1
    send(8'h3C, 4'd12, 4'd2, 3'd1, 18, 4'd2, 1'b0);  // len > WIDTH -> 8
    send(8'h01, 4'd1, 4'd15, 3'd7, 114, 4'd15, 1'b1); // max repeat, max gap

    // Abort and retrigger
    pattern = 8'h15; len = 4'd5; repeat_n = 4'd1; gap = 3'd0; start = 1'b1;
    @(negedge clk);                 // bit 1
    start = 1'b0;
    @(negedge clk);                 // bit 2: start pulse must be ignored
    start = 1'b1;
    @(negedge clk);                 // bit 3
    start = 1'b0;
    lit("abort_bit3_out", 32'(out_bit), 32'h1);
    lit("abort_bit3_led", 32'(led), 32'h2);
    reset = 1'b1;
    @(negedge clk);
    lit("abort_rst_led", 32'(led), 32'h1);
    lit("abort_rst_flags", 32'({valid, busy, done, out_bit}), 32'h0);
    lit("abort_rst_frame_cnt", 32'(frame_cnt), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    send(8'h15, 4'd5, 4'd1, 3'd0, 6, 4'd1, 1'b1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
